// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, an input synchronizer and frame-error detection.
// Completed bytes are signalled with a one-cycle o_rx_done pulse; bad stop bits pulse o_frame_err.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done,
    output logic            o_frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic              rx_meta;
    logic              rx_s;
    logic [DVSR_W-1:0] tick_cnt;
    logic              tick;
    logic [2:0]        state;
    logic [3:0]        s;
    logic [NW-1:0]     n;
    logic [DBIT-1:0]   b;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running so the sampling phase only depends on when the start edge lands.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == DVSR_W'(DVSR - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                // A start bit that is gone by its midpoint is a glitch, not a frame.
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            b <= {rx_s, b[DBIT-1:1]};
                            s <= '0;
                            if (n == NW'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == 4'(SB_TICK - 1)) begin
                            if (rx_s) begin
                                o_data    <= b;
                                o_rx_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                o_frame_err <= 1'b1;
                                state       <= BREAK;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                // Hold here until the line returns high so a stuck-low line yields one error only.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: deserializes 8N1 frames from the serial pin into bytes and signals each completed byte with a single-cycle pulse. Sits directly upstream of the operand/opcode collector, which consumes `o_data`/`o_rx_done` as its `i_data`/`i_rx_done`. Contains its own 16x-oversampling baud tick generator, input synchronizer and frame-error detection.

## Interface
- `DBIT`, 8: data bits per frame; equals the downstream byte width.
- `SB_TICK`, 16: oversampling ticks spent in the stop bit (16 = 1 stop bit).
- `DVSR`, 163: `i_clk` cycles per oversampling tick (`f_clk / (16 * baud)`; 163 gives 50 MHz / 19200).
- `DVSR_W`, 8: tick counter width; must satisfy `2^DVSR_W > DVSR`.

- `i_clk` in 1: system clock; all logic on rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_rx` in 1: serial line; idle high; asynchronous to `i_clk`.
- `o_data` out DBIT: last correctly received byte, LSB first on the line.
- `o_rx_done` out 1: one-cycle pulse; `o_data` is valid in the same cycle.
- `o_frame_err` out 1: one-cycle pulse; stop bit sampled low.

## Operation
- Synchronizer: `i_rx` passes through 2 flops (reset value 1) before the FSM. Only the synchronized signal `rx_s` is used.
- Tick generator: free-running counter 0..DVSR-1. `tick` is high for one cycle when the counter equals DVSR-1, then the counter wraps to 0. The counter runs in every state.
- FSM state registers:
  - `s`: 4-bit tick count.
  - `n`: bit count, width `$clog2(DBIT)`.
  - `b`: DBIT-bit shift register.
- States:
  - IDLE: when `rx_s`==0, go to START and clear `s`.
  - START: on each tick, increment `s`. At the tick where `s`==7 (mid start bit):
    - if `rx_s`==0, clear `s` and `n` and go to DATA;
    - if `rx_s`==1, treat as a glitch and return to IDLE.
  - DATA: on each tick, increment `s`. At the tick where `s`==15, sample: `b <= {rx_s, b[DBIT-1:1]}`, clear `s`.
    - if `n`==DBIT-1, go to STOP;
    - otherwise increment `n`.
  - STOP: on each tick, increment `s`. At the tick where `s`==SB_TICK-1, sample `rx_s`:
    - 1: load `o_data <= b`, pulse `o_rx_done`, go to IDLE;
    - 0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from producing spurious frames.
- `o_rx_done` and `o_frame_err` are never high in the same cycle.
- Reset values: state IDLE; `s`, `n`, `b`, `o_data` = 0; `o_rx_done` = 0; `o_frame_err` = 0; tick counter = 0; synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately with no pulse. After release, a line that is still low in mid-frame is treated as a new start edge. Discarding it is the glitch filter's job only if it is shorter than 8 ticks.

## Timing
- Latency: 2 cycles (synchronizer) from an `i_rx` edge to FSM visibility.
- `o_rx_done` rises in the cycle after the STOP-state tick with `s`==SB_TICK-1. It is high for exactly 1 `i_clk` cycle.
- Sampling phase error: at most 1 tick plus 2 clocks, because the tick generator is free-running.
- Start-to-done time ≈ (1 + DBIT) × 16 + SB_TICK ticks, minus 8 ticks. `o_rx_done` occurs about half a bit before the nominal end of the stop bit, which leaves margin for back-to-back frames.
- Back-to-back frames are accepted with zero idle bits: the next start edge is detected from IDLE in the first cycle after `o_rx_done`.
- `o_data` is held until the next good frame. Downstream may sample it at any time after the pulse.

## Test plan
For all scenarios: DVSR=4, bit period = 64 clocks.

- Reset: hold `i_reset`=0 with `i_rx`=1, then release. Required: `o_data`=0x00, no pulse on either output for 2000 cycles.
- Single frame 0x55: required `o_data`=0x55 and exactly one `o_rx_done` pulse, one cycle wide; `o_frame_err` stays 0.
- Three back-to-back frames 0x05, 0x03, 0x20 with no idle gap: required three `o_rx_done` pulses with `o_data`=0x05, 0x03, 0x20 in order. The downstream collector outputs A=0x05, B=0x03, OPCODE=0x20.
- Glitch: `i_rx` low for 3 ticks (12 clocks), then high. Required: no pulse, FSM back in IDLE. A following frame 0xA5 is received correctly.
- Framing error: frame 0xA5 with stop bit 0, line held low for 2 bit times, then high, then frame 0x3C. Required:
  - exactly one `o_frame_err` pulse;
  - `o_data` unchanged by the bad frame (still previous value);
  - a single `o_rx_done` with `o_data`=0x3C.
- Reset mid-frame: assert `i_reset` during data bit 4 of 0xFF, release with the line high, then send 0x81. Required: no pulse for the aborted frame; a single `o_rx_done` with `o_data`=0x81.
